reg_file_mp: RTL and testbench

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_pkg.sv | 16 +
 rtl/reg_file_clr_seq.sv | 37 +++
 rtl/reg_file_mp.sv | 98 +++++++++
 tb/tb_reg_file_mp.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared types and width constants for the multi-port register file.
// Holds the clear/ready state encoding plus default and FPGA-build widths.
package reg_file_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_t;

    localparam int DATA_WIDTH_DEF  = 32;
    localparam int ADDR_WIDTH_DEF  = 5;

    localparam int DATA_WIDTH_FPGA = 4;
    localparam int ADDR_WIDTH_FPGA = 2;

endpackage

// File: rtl/reg_file_clr_seq.sv
// Clear sequencer: walks every entry once after reset, then parks in READY.
// One entry per cycle, so clearing takes exactly DEPTH cycles after rst drops.
module reg_file_clr_seq
    import reg_file_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  busy,
    output logic                  clr_en,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;

    rf_state_t             state;
    logic [ADDR_WIDTH-1:0] clr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else if (state == CLEAR) begin
            clr_ptr <= clr_ptr + PTR_ONE;
            // Pointer wraps back to 0 on the last entry, ready for the next clear.
            if (clr_ptr == '1) begin
                state <= READY;
            end
        end
    end

    assign busy     = (state == CLEAR);
    assign clr_en   = (state == CLEAR) && !rst;
    assign clr_addr = clr_ptr;

endmodule

// File: rtl/reg_file_mp.sv
// Two-write / two-read register file with hardware clear, optional zero register
// and optional same-cycle write-to-read forwarding; flags discarded writes on wr_drop.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen0,
    input  logic [ADDR_WIDTH-1:0] waddr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic                  wen1,
    input  logic [ADDR_WIDTH-1:0] waddr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] rdata2,
    output logic                  busy,
    output logic                  wr_drop
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  clr_en;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  ready;
    logic                  zero0;
    logic                  zero1;
    logic                  we0_ok;
    logic                  we1_ok;
    logic                  collide;

    reg_file_clr_seq #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_clr_seq (
        .clk     (clk),
        .rst     (rst),
        .busy    (busy),
        .clr_en  (clr_en),
        .clr_addr(clr_addr)
    );

    assign ready = !busy;

    // Writes aimed at the hard-wired zero register vanish without a drop flag.
    assign zero0   = (ZERO_REG != 0) && (waddr0 == '0);
    assign zero1   = (ZERO_REG != 0) && (waddr1 == '0);
    assign we0_ok  = ready && wen0 && !zero0;
    assign we1_ok  = ready && wen1 && !zero1;
    assign collide = ready && wen0 && wen1 && (waddr0 == waddr1) && !zero0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_en) begin
                mem[clr_addr] <= '0;
            end else begin
                if (we0_ok) mem[waddr0] <= wdata0;
                // Port 1 is written last so it wins an address collision.
                if (we1_ok) mem[waddr1] <= wdata1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_drop <= 1'b0;
        end else if (busy) begin
            wr_drop <= wen0 || wen1;
        end else begin
            wr_drop <= collide;
        end
    end

    function automatic logic [DATA_WIDTH-1:0] read_mux(input logic [ADDR_WIDTH-1:0] ra);
        logic [DATA_WIDTH-1:0] val;
        val = mem[ra];
        if ((BYPASS != 0) && ready) begin
            if (wen0 && (waddr0 == ra)) val = wdata0;
            if (wen1 && (waddr1 == ra)) val = wdata1;
        end
        if ((ZERO_REG != 0) && (ra == '0)) val = '0;
        if (rst || busy) val = '0;
        return val;
    endfunction

    always_comb begin
        rdata1 = read_mux(raddr1);
        rdata2 = read_mux(raddr2);
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: default bypass build, a non-bypass build and a small FPGA build
// driven side by side and checked against a behavioural register-file model.
module tb_reg_file_mp;
    import reg_file_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam int SDW   = DATA_WIDTH_FPGA;
    localparam int SAW   = ADDR_WIDTH_FPGA;

    logic          clk = 1'b0;
    logic          rst;
    logic          wen0, wen1;
    logic [AW-1:0] waddr0, waddr1, raddr1, raddr2;
    logic [DW-1:0] wdata0, wdata1;
    logic [DW-1:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic          busy_b, busy_n, drop_b, drop_n;

    logic           s_wen0, s_wen1;
    logic [SAW-1:0] s_waddr0, s_waddr1, s_raddr1, s_raddr2;
    logic [SDW-1:0] s_wdata0, s_wdata1, s_rd1, s_rd2;
    logic           s_busy, s_drop;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mdl [DEPTH];
    int            clear_left;
    logic          exp_drop;

    always #5 clk = ~clk;

    reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1), .BYPASS(1)) dut_b (
        .clk(clk), .rst(rst),
        .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
        .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_b), .rdata2(rd2_b),
        .busy(busy_b), .wr_drop(drop_b)
    );

    reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1), .BYPASS(0)) dut_n (
        .clk(clk), .rst(rst),
        .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
        .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_n), .rdata2(rd2_n),
        .busy(busy_n), .wr_drop(drop_n)
    );

    reg_file_mp #(.DATA_WIDTH(SDW), .ADDR_WIDTH(SAW), .ZERO_REG(1), .BYPASS(1)) dut_s (
        .clk(clk), .rst(rst),
        .wen0(s_wen0), .waddr0(s_waddr0), .wdata0(s_wdata0),
        .wen1(s_wen1), .waddr1(s_waddr1), .wdata1(s_wdata1),
        .raddr1(s_raddr1), .raddr2(s_raddr2), .rdata1(s_rd1), .rdata2(s_rd2),
        .busy(s_busy), .wr_drop(s_drop)
    );

    // Expected read value: zero while clearing/reset or at address 0, else newest write wins.
    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
        if (rst || clear_left > 0) return '0;
        if (a == 0) return '0;
        if (byp && wen1 && waddr1 == a) return wdata1;
        if (byp && wen0 && waddr0 == a) return wdata0;
        return mdl[a];
    endfunction

    task automatic model_edge();
        if (rst) begin
            clear_left = DEPTH;
            exp_drop   = 1'b0;
        end else if (clear_left > 0) begin
            exp_drop   = wen0 || wen1;
            clear_left = clear_left - 1;
            if (clear_left == 0) begin
                for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
            end
        end else begin
            exp_drop = wen0 && wen1 && (waddr0 == waddr1) && (waddr0 != 0);
            if (wen0 && waddr0 != 0) mdl[waddr0] = wdata0;
            if (wen1 && waddr1 != 0) mdl[waddr1] = wdata1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        wen0 = 0; wen1 = 0; waddr0 = 0; waddr1 = 0; wdata0 = 0; wdata1 = 0;
        s_wen0 = 0; s_wen1 = 0; s_waddr0 = 0; s_waddr1 = 0; s_wdata0 = 0; s_wdata1 = 0;
    endtask

    task automatic test_reset();
        int n, s_n;
        idle();
        rst = 1; raddr1 = 5'd9; raddr2 = 5'd17; s_raddr1 = 2'd1; s_raddr2 = 2'd2;
        tick(); tick();
        total += 4;
        if (busy_b !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b want=1", busy_b); end
        if (drop_b !== 1'b0) begin bad++; $display("FAIL reset_drop got=%b want=0", drop_b); end
        if (rd1_b !== '0) begin bad++; $display("FAIL reset_rd1 got=%h want=0", rd1_b); end
        if (rd2_n !== '0) begin bad++; $display("FAIL reset_rd2 got=%h want=0", rd2_n); end
        rst = 0;
        n = 0; s_n = -1;
        while (busy_b === 1'b1 && n < 100) begin
            tick();
            n++;
            if (s_busy === 1'b0 && s_n < 0) s_n = n;
        end
        total += 2;
        if (n != 32) begin bad++; $display("FAIL clear_len got=%0d want=32", n); end
        if (s_n != 4) begin bad++; $display("FAIL small_clear_len got=%0d want=4", s_n); end
        for (int i = 0; i < DEPTH; i++) begin
            raddr1 = AW'(i); raddr2 = AW'(DEPTH - 1 - i);
            #1;
            total += 2;
            if (rd1_b !== '0) begin bad++; $display("FAIL clear_entry_%0d got=%h want=0", i, rd1_b); end
            if (rd2_n !== '0) begin bad++; $display("FAIL clear_entry_n_%0d got=%h want=0", DEPTH - 1 - i, rd2_n); end
        end
    endtask

    task automatic test_bypass();
        idle();
        wen0 = 1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF; raddr1 = 5'd5;
        #2;
        total += 2;
        if (rd1_b !== 32'hDEADBEEF) begin bad++; $display("FAIL bypass_same got=%h want=deadbeef", rd1_b); end
        if (rd1_n !== 32'h0) begin bad++; $display("FAIL nobypass_same got=%h want=0", rd1_n); end
        tick();
        wen0 = 0;
        #1;
        total += 3;
        if (rd1_n !== 32'hDEADBEEF) begin bad++; $display("FAIL nobypass_next got=%h want=deadbeef", rd1_n); end
        if (rd1_b !== 32'hDEADBEEF) begin bad++; $display("FAIL bypass_next got=%h want=deadbeef", rd1_b); end
        if (drop_b !== 1'b0) begin bad++; $display("FAIL bypass_drop got=%b want=0", drop_b); end
    endtask

    task automatic test_collision();
        idle();
        wen0 = 1; wen1 = 1; waddr0 = 5'd7; waddr1 = 5'd7; wdata0 = 32'h11; wdata1 = 32'h22;
        raddr2 = 5'd7;
        #2;
        total += 1;
        if (rd2_b !== 32'h22) begin bad++; $display("FAIL collide_bypass got=%h want=22", rd2_b); end
        tick();
        idle();
        raddr1 = 5'd7;
        #1;
        total += 3;
        if (drop_b !== 1'b1) begin bad++; $display("FAIL collide_drop got=%b want=1", drop_b); end
        if (rd1_b !== 32'h22) begin bad++; $display("FAIL collide_val got=%h want=22", rd1_b); end
        if (rd1_n !== 32'h22) begin bad++; $display("FAIL collide_val_n got=%h want=22", rd1_n); end
        tick();
        total += 1;
        if (drop_b !== 1'b0) begin bad++; $display("FAIL collide_drop_clear got=%b want=0", drop_b); end
    endtask

    task automatic test_zero_reg();
        idle();
        wen0 = 1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF;
        wen1 = 1; waddr1 = 5'd0; wdata1 = 32'h12345678;
        raddr1 = 5'd0;
        #2;
        total += 1;
        if (rd1_b !== 32'h0) begin bad++; $display("FAIL zero_bypass got=%h want=0", rd1_b); end
        tick();
        idle();
        #1;
        total += 2;
        if (drop_b !== 1'b0) begin bad++; $display("FAIL zero_drop got=%b want=0", drop_b); end
        if (rd1_b !== 32'h0) begin bad++; $display("FAIL zero_read got=%h want=0", rd1_b); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst    = ($urandom_range(0, 149) == 0);
            wen0   = $urandom_range(0, 1) == 1;
            wen1   = $urandom_range(0, 1) == 1;
            waddr0 = AW'($urandom_range(0, 7));
            waddr1 = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            wdata0 = $urandom;
            wdata1 = $urandom;
            raddr1 = ($urandom_range(0, 2) == 0) ? waddr0 : AW'($urandom_range(0, 7));
            raddr2 = ($urandom_range(0, 2) == 0) ? waddr1 : AW'($urandom);
            #2;
            total += 4;
            if (rd1_b !== exp_rd(raddr1, 1)) begin bad++; $display("FAIL rand_rd1_b c=%0d got=%h want=%h", c, rd1_b, exp_rd(raddr1, 1)); end
            if (rd2_b !== exp_rd(raddr2, 1)) begin bad++; $display("FAIL rand_rd2_b c=%0d got=%h want=%h", c, rd2_b, exp_rd(raddr2, 1)); end
            if (rd1_n !== exp_rd(raddr1, 0)) begin bad++; $display("FAIL rand_rd1_n c=%0d got=%h want=%h", c, rd1_n, exp_rd(raddr1, 0)); end
            if (rd2_n !== exp_rd(raddr2, 0)) begin bad++; $display("FAIL rand_rd2_n c=%0d got=%h want=%h", c, rd2_n, exp_rd(raddr2, 0)); end
            tick();
            total += 3;
            if (drop_b !== exp_drop) begin bad++; $display("FAIL rand_drop c=%0d got=%b want=%b", c, drop_b, exp_drop); end
            if (drop_n !== exp_drop) begin bad++; $display("FAIL rand_drop_n c=%0d got=%b want=%b", c, drop_n, exp_drop); end
            if (busy_b !== (clear_left > 0)) begin bad++; $display("FAIL rand_busy c=%0d got=%b want=%b", c, busy_b, clear_left > 0); end
        end
        rst = 0;
        idle();
        for (int k = 0; k < 40 && clear_left > 0; k++) tick();
    endtask

    task automatic test_mid_clear_reset();
        int n;
        idle();
        rst = 1; tick(); rst = 0;
        for (int k = 0; k < 10; k++) tick();
        rst = 1; tick(); rst = 0;
        n = 0;
        while (busy_b === 1'b1 && n < 100) begin
            if (n == 5) begin wen0 = 1; waddr0 = 5'd9; wdata0 = 32'h55; end
            else wen0 = 0;
            tick();
            n++;
            if (n == 6) begin
                total += 1;
                if (drop_b !== 1'b1) begin bad++; $display("FAIL clear_write_drop got=%b want=1", drop_b); end
            end
        end
        idle();
        raddr1 = 5'd9;
        #1;
        total += 2;
        if (n != 32) begin bad++; $display("FAIL rerun_clear_len got=%0d want=32", n); end
        if (rd1_b !== 32'h0) begin bad++; $display("FAIL clear_write_lost got=%h want=0", rd1_b); end
    endtask

    task automatic test_small();
        idle();
        s_wen0 = 1; s_waddr0 = 2'd3; s_wdata0 = 4'hA;
        tick();
        s_wen0 = 0; s_raddr1 = 2'd3; s_raddr2 = 2'd0;
        #1;
        total += 3;
        if (s_rd1 !== 4'hA) begin bad++; $display("FAIL small_wrap_read got=%h want=a", s_rd1); end
        if (s_rd2 !== 4'h0) begin bad++; $display("FAIL small_zero_read got=%h want=0", s_rd2); end
        if (s_drop !== 1'b0) begin bad++; $display("FAIL small_drop got=%b want=0", s_drop); end
    endtask

    initial begin
        clear_left = DEPTH;
        exp_drop   = 1'b0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        rst = 1;
        idle();
        raddr1 = 0; raddr2 = 0; s_raddr1 = 0; s_raddr2 = 0;
        @(negedge clk);
        test_reset();
        test_bypass();
        test_collision();
        test_zero_reg();
        test_random();
        test_mid_clear_reset();
        test_small();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
